// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        EMIT
    } state_t;

    localparam int DIG_W       = 4;
    localparam int ADD3_THRESH = 5;

    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_if.sv
// Handshake bundle: binary word in, BCD digit stream out.
interface bin2bcd_if import bin2bcd_pkg::*; #(
    parameter int BIN_W = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [BIN_W-1:0] bin_in;
    logic             dig_valid;
    logic             dig_ready;
    logic [DIG_W-1:0] dig;
    logic             dig_last;
    logic             ovf;

    modport master (
        output in_valid, bin_in, dig_ready,
        input  in_ready, dig_valid, dig, dig_last, ovf
    );

    modport slave (
        input  in_valid, bin_in, dig_ready,
        output in_ready, dig_valid, dig, dig_last, ovf
    );
endinterface

// File: rtl/bin2bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every digit >= 5, then shift left taking bit_in.
module bin2bcd_dabble_step import bin2bcd_pkg::*; #(
    parameter int DIGITS = 3
) (
    input  logic [DIG_W*DIGITS-1:0] bcd_in,
    input  logic                    bit_in,
    output logic [DIG_W*DIGITS-1:0] bcd_out
);
    logic [DIG_W*DIGITS-1:0] adj;

    always_comb begin
        adj = bcd_in;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_in[i*DIG_W +: DIG_W] >= DIG_W'(ADD3_THRESH))
                adj[i*DIG_W +: DIG_W] = bcd_in[i*DIG_W +: DIG_W] + 4'd3;
        end
    end

    // Carry out of the top digit falls off here.
    assign bcd_out = {adj[DIG_W*DIGITS-2:0], bit_in};
endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, digits streamed MS first.
// Optional saturation to all-9s on overflow: define BIN2BCD_SAT_EN.
module bin2bcd_seq import bin2bcd_pkg::*; #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic      clk,
    input  logic      rst_n,
    bin2bcd_if.slave  bus
);
    localparam int BCD_W = DIG_W * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_W - 1);
    localparam logic [IDX_W-1:0] TOP_IDX   = IDX_W'(DIGITS - 1);

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d, bcd_step;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DIG_W-1:0]   dig_q, dig_d;
    logic               in_ready_q, in_ready_d;
    logic               dig_valid_q, dig_valid_d;
    logic               dig_last_q, dig_last_d;
    logic               ovf_q, ovf_d;
    logic               ovf_in;

    bin2bcd_dabble_step #(.DIGITS(DIGITS)) u_step (
        .bcd_in  (bcd_q),
        .bit_in  (bin_q[BIN_W-1]),
        .bcd_out (bcd_step)
    );

`ifdef BIN2BCD_SAT_EN
    localparam logic [63:0] SAT_LIMIT = 64'(pow10(DIGITS) - 1);
    assign ovf_in = (64'(bus.bin_in) > SAT_LIMIT);
`else
    assign ovf_in = 1'b0;
`endif

    function automatic logic [DIG_W-1:0] pick(input logic [BCD_W-1:0] b,
                                              input logic [IDX_W-1:0] i,
                                              input logic             sat);
        return sat ? 4'd9 : b[i*DIG_W +: DIG_W];
    endfunction

    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        bcd_d       = bcd_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        dig_d       = dig_q;
        in_ready_d  = in_ready_q;
        dig_valid_d = dig_valid_q;
        dig_last_d  = dig_last_q;
        ovf_d       = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    state_d    = CONVERT;
                    bin_d      = bus.bin_in;
                    bcd_d      = '0;
                    cnt_d      = '0;
                    ovf_d      = ovf_in;
                    in_ready_d = 1'b0;
                end else begin
                    in_ready_d = 1'b1;
                end
            end
            CONVERT: begin
                bin_d = bin_q << 1;
                bcd_d = bcd_step;
                cnt_d = cnt_q + 1'b1;
                // Present the MS digit on the same edge as the final step.
                if (cnt_q == LAST_STEP) begin
                    state_d     = EMIT;
                    idx_d       = TOP_IDX;
                    dig_valid_d = 1'b1;
                    dig_d       = pick(bcd_step, TOP_IDX, ovf_q);
                    dig_last_d  = (DIGITS == 1);
                end
            end
            EMIT: begin
                if (bus.dig_ready) begin
                    if (idx_q == '0) begin
                        state_d     = IDLE;
                        dig_valid_d = 1'b0;
                        dig_last_d  = 1'b0;
                        in_ready_d  = 1'b1;
                    end else begin
                        idx_d      = idx_q - 1'b1;
                        dig_d      = pick(bcd_q, idx_q - 1'b1, ovf_q);
                        dig_last_d = (idx_q == IDX_W'(1));
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bin_q       <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            dig_q       <= '0;
            in_ready_q  <= 1'b0;
            dig_valid_q <= 1'b0;
            dig_last_q  <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            bcd_q       <= bcd_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            dig_q       <= dig_d;
            in_ready_q  <= in_ready_d;
            dig_valid_q <= dig_valid_d;
            dig_last_q  <= dig_last_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.dig_valid = dig_valid_q;
    assign bus.dig       = dig_q;
    assign bus.dig_last  = dig_last_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq (8-bit / 3-digit main instance, 2-digit overflow instance).
module tb_bin2bcd_seq;
    import bin2bcd_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bin2bcd_if #(.BIN_W(8)) bus ();
    bin2bcd_if #(.BIN_W(8)) bus2 ();

    bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) dut (
        .clk (clk), .rst_n (rst_n), .bus (bus.slave)
    );
    bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) dut2 (
        .clk (clk), .rst_n (rst_n), .bus (bus2.slave)
    );

    int errors = 0;
    int checks = 0;
    int got_dig  [6];
    int got_last [6];
    int got_ovf  [6];
    int pat [6] = '{0, 1, 0, 0, 1, 1};

    typedef struct {
        logic [7:0] bin;
        int d2, d1, d0;
        int mode;
    } vec_t;
    vec_t vt [6];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] v);
        int w;
        w = 0;
        @(negedge clk);
        while (!bus.in_ready) begin
            w++;
            if (w > 100) begin
                check("send_timeout", 0, 1);
                return;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b1;
        bus.bin_in   = v;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    // mode 0: always ready; 1: stall pattern with in_valid pulses while stalled; 2: random ready
    task automatic recv(input int n, input int base, input int mode);
        int k, step, wait_cnt, r;
        logic held_v;
        logic [3:0] hd;
        logic hl, ho;
        k = 0; step = 0; wait_cnt = 0; held_v = 1'b0; hd = '0; hl = 1'b0; ho = 1'b0;
        while (k < n) begin
            @(negedge clk);
            if (held_v && bus.dig_valid) begin
                check("stall_dig",  int'(bus.dig),      int'(hd));
                check("stall_last", int'(bus.dig_last), int'(hl));
                check("stall_ovf",  int'(bus.ovf),      int'(ho));
            end
            held_v = 1'b0;
            if (!bus.dig_valid) begin
                bus.dig_ready = 1'b0;
                wait_cnt++;
                if (wait_cnt > 100) begin
                    check("recv_timeout", 0, 1);
                    return;
                end
                continue;
            end
            wait_cnt = 0;
            r = (mode == 0) ? 1 : (mode == 1) ? pat[step % 6] : int'($urandom_range(0, 1));
            step++;
            bus.dig_ready = (r != 0);
            if (mode == 1) begin
                bus.in_valid = (r == 0);
                bus.bin_in   = 8'd5;
            end
            if (r != 0) begin
                got_dig[base+k]  = int'(bus.dig);
                got_last[base+k] = int'(bus.dig_last);
                got_ovf[base+k]  = int'(bus.ovf);
                k++;
            end else begin
                held_v = 1'b1;
                hd = bus.dig; hl = bus.dig_last; ho = bus.ovf;
            end
        end
    endtask

    task automatic check_word(input string name, input int base, input int d2, input int d1, input int d0);
        check({name, "_d2"}, got_dig[base],   d2);
        check({name, "_d1"}, got_dig[base+1], d1);
        check({name, "_d0"}, got_dig[base+2], d0);
        check({name, "_last"}, got_last[base]*4 + got_last[base+1]*2 + got_last[base+2], 1);
        check({name, "_ovf"}, got_ovf[base] + got_ovf[base+1] + got_ovf[base+2], 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt, gap;
        bus.in_valid = 1'b0; bus.bin_in = '0; bus.dig_ready = 1'b0;
        bus2.in_valid = 1'b0; bus2.bin_in = '0; bus2.dig_ready = 1'b0;

        vt[0] = '{8'd123, 1, 2, 3, 0};
        vt[1] = '{8'd9,   0, 0, 9, 2};
        vt[2] = '{8'd100, 1, 0, 0, 0};
        vt[3] = '{8'd250, 2, 5, 0, 2};
        vt[4] = '{8'd199, 1, 9, 9, 0};
        vt[5] = '{8'd64,  0, 6, 4, 2};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready",  int'(bus.in_ready), 0);
        check("rst_dig_valid", int'(bus.dig_valid), 0);
        check("rst_dig",       int'(bus.dig), 0);
        check("rst_dig_last",  int'(bus.dig_last), 0);
        check("rst_ovf",       int'(bus.ovf), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_release_ready", int'(bus.in_ready), 1);

        // Zero word and latency
        send(8'd0);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
            if (cnt == 1) check("accept_ready_low", int'(bus.in_ready), 0);
        end while (!bus.dig_valid && cnt < 100);
        check("latency", cnt - 1, 8);
        recv(3, 0, 0);
        check_word("zero", 0, 0, 0, 0);

        // Back-to-back 255 then 47
        fork
            begin
                @(negedge clk);
                check("b2b_ready", int'(bus.in_ready), 1);
                bus.in_valid = 1'b1;
                bus.bin_in   = 8'd255;
                @(posedge clk);
                #1 bus.bin_in = 8'd47;
                gap = 0;
                @(negedge clk);
                while (!bus.in_ready && gap < 100) begin
                    gap++;
                    @(negedge clk);
                end
                check("b2b_gap", gap, 11);
                @(posedge clk);
                #1 bus.in_valid = 1'b0;
            end
            begin
                recv(3, 0, 0);
                recv(3, 3, 0);
            end
        join
        check_word("w255", 0, 2, 5, 5);
        check_word("w47",  3, 0, 4, 7);

        // Stalled output, in_valid pulses during EMIT
        send(8'd99);
        recv(3, 0, 1);
        check_word("w99", 0, 0, 9, 9);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("post99_ready", int'(bus.in_ready), 1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("ignored_pulse", int'(bus.dig_valid), 0);
        end

        // Reset mid-conversion
        send(8'd200);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_ready", int'(bus.in_ready), 0);
        check("midrst_valid", int'(bus.dig_valid), 0);
        check("midrst_dig",   int'(bus.dig), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_valid2", int'(bus.dig_valid), 0);
        send(8'd13);
        recv(3, 0, 0);
        check_word("w13", 0, 0, 1, 3);

        // Table vectors
        for (int i = 0; i < 6; i++) begin
            send(vt[i].bin);
            recv(3, 0, vt[i].mode);
            check_word($sformatf("vec%0d", i), 0, vt[i].d2, vt[i].d1, vt[i].d0);
        end

        // Two-digit instance, overflowing word
        @(negedge clk);
        check("d2_ready", int'(bus2.in_ready), 1);
        bus2.in_valid = 1'b1;
        bus2.bin_in   = 8'd200;
        @(posedge clk);
        #1 bus2.in_valid = 1'b0;
        bus2.dig_ready = 1'b1;
        cnt = 0;
        gap = 0;
        while (cnt < 2 && gap < 100) begin
            @(negedge clk);
            gap++;
            if (bus2.dig_valid) begin
                got_dig[cnt]  = int'(bus2.dig);
                got_last[cnt] = int'(bus2.dig_last);
                got_ovf[cnt]  = int'(bus2.ovf);
                cnt++;
            end
        end
        check("d2_count", cnt, 2);
`ifdef BIN2BCD_SAT_EN
        check("d2_dig1", got_dig[0], 9);
        check("d2_dig0", got_dig[1], 9);
        check("d2_ovf1", got_ovf[0], 1);
        check("d2_ovf0", got_ovf[1], 1);
`else
        check("d2_dig1", got_dig[0], 0);
        check("d2_dig0", got_dig[1], 0);
        check("d2_ovf1", got_ovf[0], 0);
        check("d2_ovf0", got_ovf[1], 0);
`endif
        check("d2_last", got_last[0]*2 + got_last[1], 1);
        @(negedge clk);
        bus2.dig_ready = 1'b0;

        // Exhaustive sweep with random back-pressure
        for (int v = 0; v < 256; v++) begin
            send(8'(v));
            recv(3, 0, 2);
            check("sweep_d2", got_dig[0], v / 100);
            check("sweep_d1", got_dig[1], (v / 10) % 10);
            check("sweep_d0", got_dig[2], v % 10);
            check("sweep_le9", int'(got_dig[0] <= 9 && got_dig[1] <= 9 && got_dig[2] <= 9), 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
